mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares one read port and one write port of the single-bank `Memory` between `NUM_REQ` requesters, for example instruction fetch and load/store. Each requester issues one word access through a valid/ready handshake. The arbiter drives the memory ports for a programmable number of cycles, captures the result and returns a one-cycle response to the winning requester. Only one transaction is in flight at a time.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read port and one write port
// between NUM_REQ requesters; one transaction in flight at a time.
module mem_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic                          resp_err,
    output logic                          mem_read_enable,
    output logic [ADDR_WIDTH-1:0]         mem_read_addr,
    input  logic [DATA_WIDTH-1:0]         mem_read_data,
    output logic                          mem_write_enable,
    output logic [ADDR_WIDTH-1:0]         mem_write_addr,
    output logic [DATA_WIDTH-1:0]         mem_write_data,
    output logic                          busy
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [GW-1:0] LAST_REQ = GW'(NUM_REQ - 1);
    localparam logic [GW:0] NREQ_W = (GW+1)'(NUM_REQ);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] ADDR_LIM = (ADDR_WIDTH+1)'(MEM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [GW-1:0]         r_rr_ptr;
    logic [GW-1:0]         r_gnt;
    logic [GW-1:0]         w_gnt;
    logic [GW:0]           w_idx;
    logic                  w_found;
    logic                  w_accept;
    logic [CW-1:0]         r_cnt;
    logic                  r_err;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_resp_err;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_rr_ptr;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (GW+1)'(i);
            if (w_idx >= NREQ_W) begin
                w_idx = w_idx - NREQ_W;
            end
            if (!w_found && req_valid[w_idx[GW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[GW-1:0];
            end
        end
    end

    assign w_addr  = req_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata = req_wdata[w_gnt*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        req_ready = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found && !reset) begin
                    w_accept         = 1'b1;
                    req_ready[w_gnt] = 1'b1;
                    w_next           = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_gnt      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_resp_err <= 1'b0;
        end else if (w_accept) begin
            r_gnt    <= w_gnt;
            r_we     <= req_we[w_gnt];
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_err    <= ({1'b0, w_addr} >= ADDR_LIM);
            r_cnt    <= CNT_INIT;
            r_rr_ptr <= (w_gnt == LAST_REQ) ? '0 : w_gnt + 1'b1;
        end else if (r_state == S_BUSY) begin
            if (r_cnt == '0) begin
                r_rdata    <= (r_we || r_err) ? '0 : mem_read_data;
                r_resp_err <= r_err;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = (r_state == S_RESP) && (r_gnt == GW'(i));
        end
    end

    // Counter still at its load value only in the first BUSY cycle.
    assign mem_write_enable = (r_state == S_BUSY) && r_we && !r_err
                              && (r_cnt == CNT_INIT);
    assign mem_read_enable  = (r_state == S_BUSY) && !r_we && !r_err;
    assign mem_read_addr    = r_addr;
    assign mem_write_addr   = r_addr;
    assign mem_write_data   = r_wdata;
    assign resp_rdata       = r_rdata;
    assign resp_err         = r_resp_err;
    assign busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances at LATENCY 1, 3 and 4,
// each with its own behavioural memory.
module tb_mem_port_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MS = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    rv [3];
    logic [NR-1:0]    rr [3];
    logic [NR-1:0]    rwe [3];
    logic [NR-1:0]    respv [3];
    logic [NR*AW-1:0] ra [3];
    logic [NR*DW-1:0] rw [3];
    logic [DW-1:0]    rdata [3];
    logic             rerr [3];
    logic             m_re [3];
    logic             m_we [3];
    logic             bsy [3];
    logic [AW-1:0]    m_ra [3];
    logic [AW-1:0]    m_wa [3];
    logic [DW-1:0]    m_rd [3];
    logic [DW-1:0]    m_wd [3];

    logic       pre_en = 1'b0;
    int         pre_k = 0;
    logic [9:0] pre_a = '0;
    logic [DW-1:0] pre_d = '0;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        logic [DW-1:0] mem [MS];
        int wcnt = 0;

        mem_port_arbiter #(
            .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
            .MEM_SIZE(MS), .LATENCY(k == 0 ? 1 : k + 2)
        ) u_dut (
            .clk(clk), .reset(rst),
            .req_valid(rv[k]), .req_ready(rr[k]), .req_we(rwe[k]),
            .req_addr(ra[k]), .req_wdata(rw[k]),
            .resp_valid(respv[k]), .resp_rdata(rdata[k]),
            .resp_err(rerr[k]),
            .mem_read_enable(m_re[k]), .mem_read_addr(m_ra[k]),
            .mem_read_data(m_rd[k]),
            .mem_write_enable(m_we[k]), .mem_write_addr(m_wa[k]),
            .mem_write_data(m_wd[k]), .busy(bsy[k])
        );

        assign m_rd[k] = (m_ra[k] < MS) ? mem[m_ra[k][9:0]] : '0;

        always @(posedge clk) begin
            if (pre_en && pre_k == k) mem[pre_a] <= pre_d;
            if (m_we[k]) begin
                if (m_wa[k] < MS) mem[m_wa[k][9:0]] <= m_wd[k];
                wcnt <= wcnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pre(input int k, input int a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_en = 1'b1;
        pre_k  = k;
        pre_a  = 10'(a);
        pre_d  = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    int w0;
    logic any_resp;
    logic [NR-1:0] exp_g;

    initial begin
        for (int k = 0; k < 3; k++) begin
            rv[k] = '0; rwe[k] = '0; ra[k] = '0; rw[k] = '0;
        end
        pre(0, 5, 32'hAB);
        pre(1, 10, 32'h1010);
        pre(1, 11, 32'h1111);
        pre(2, 3, 32'h33);

        // reset state; reset also beats a valid request
        @(negedge clk); rv[0] = 2'b11; #1;
        chk("rst_ready", rr[0], 0);
        chk("rst_busy", bsy[0], 0);
        chk("rst_respv", respv[0], 0);
        chk("rst_rdata", rdata[0], 0);
        chk("rst_err", rerr[0], 0);
        chk("rst_men", {m_re[0], m_we[0]}, 0);
        chk("rst_maddr", m_ra[0], 0);
        @(negedge clk); rst = 1'b0; rv[0] = '0;

        // single read, LATENCY 1
        @(negedge clk); rv[0] = 2'b01; ra[0] = {32'd0, 32'd5}; #1;
        chk("rd_ready", rr[0], 2'b01);
        @(negedge clk); rv[0] = '0; #1;
        chk("rd_ren", m_re[0], 1);
        chk("rd_raddr", m_ra[0], 5);
        chk("rd_wen", m_we[0], 0);
        @(negedge clk); #1;
        chk("rd_respv", respv[0], 2'b01);
        chk("rd_rdata", rdata[0], 32'hAB);
        chk("rd_err", rerr[0], 0);
        chk("rd_ren_off", m_re[0], 0);
        @(negedge clk); #1;
        chk("rd_respv_off", respv[0], 0);
        chk("rd_hold", rdata[0], 32'hAB);
        chk("rd_idle", bsy[0], 0);

        // write by req1, then read back by req0
        w0 = g_dut[0].wcnt;
        rv[0] = 2'b10; rwe[0] = 2'b10;
        ra[0] = {32'd7, 32'd0}; rw[0] = {32'h1234, 32'd0}; #1;
        chk("wr_ready", rr[0], 2'b10);
        @(negedge clk); rv[0] = '0; rwe[0] = '0; #1;
        chk("wr_wen", m_we[0], 1);
        chk("wr_waddr", m_wa[0], 7);
        chk("wr_wdata", m_wd[0], 32'h1234);
        @(negedge clk); #1;
        chk("wr_respv", respv[0], 2'b10);
        chk("wr_rdata", rdata[0], 0);
        chk("wr_wen_off", m_we[0], 0);
        chk("wr_pulses", g_dut[0].wcnt - w0, 1);
        @(negedge clk); rv[0] = 2'b01; ra[0] = {32'd0, 32'd7}; #1;
        chk("rb_ready", rr[0], 2'b01);
        @(negedge clk); rv[0] = '0;
        @(negedge clk); #1;
        chk("rb_respv", respv[0], 2'b01);
        chk("rb_rdata", rdata[0], 32'h1234);

        // out-of-range read and write
        @(negedge clk); rv[0] = 2'b01; ra[0] = {32'd0, 32'd1024}; #1;
        chk("oobr_ready", rr[0], 2'b01);
        @(negedge clk); rv[0] = '0; #1;
        chk("oobr_ren", m_re[0], 0);
        chk("oobr_busy", bsy[0], 1);
        @(negedge clk); #1;
        chk("oobr_respv", respv[0], 2'b01);
        chk("oobr_err", rerr[0], 1);
        chk("oobr_rdata", rdata[0], 0);
        w0 = g_dut[0].wcnt;
        @(negedge clk); rv[0] = 2'b10; rwe[0] = 2'b10;
        ra[0] = {32'd2000, 32'd0}; rw[0] = {32'hDEAD, 32'd0}; #1;
        chk("oobw_ready", rr[0], 2'b10);
        @(negedge clk); rv[0] = '0; rwe[0] = '0; #1;
        chk("oobw_wen", m_we[0], 0);
        @(negedge clk); #1;
        chk("oobw_respv", respv[0], 2'b10);
        chk("oobw_err", rerr[0], 1);
        chk("oobw_pulses", g_dut[0].wcnt - w0, 0);

        // round robin with both requesters held, LATENCY 3
        @(negedge clk); rv[1] = 2'b11; ra[1] = {32'd11, 32'd10};
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            chk("rr_ready", rr[1], exp_g);
            for (int j = 1; j <= 3; j++) begin
                @(negedge clk); #1;
                chk("rr_wait", {rr[1], respv[1], bsy[1]}, 1);
            end
            @(negedge clk); #1;
            chk("rr_respv", respv[1], exp_g);
            chk("rr_rdata", rdata[1], (t % 2 == 1) ? 32'h1111 : 32'h1010);
            @(negedge clk);
        end
        rv[1] = '0;

        // reset mid-transaction, LATENCY 4
        @(negedge clk); rv[2] = 2'b01; ra[2] = {32'd0, 32'd3}; #1;
        chk("mr_ready0", rr[2], 2'b01);
        @(negedge clk); rv[2] = '0;
        repeat (3) @(negedge clk);
        @(negedge clk); #1;
        chk("mr_respv0", respv[2], 2'b01);
        chk("mr_rdata0", rdata[2], 32'h33);
        @(negedge clk); rv[2] = 2'b01; #1;
        chk("mr_ready1", rr[2], 2'b01);
        @(negedge clk); rv[2] = '0;
        @(negedge clk); #1;
        chk("mr_busy2", {bsy[2], m_re[2]}, 2'b11);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("mr_rst_busy", bsy[2], 0);
        chk("mr_rst_ren", m_re[2], 0);
        chk("mr_rst_respv", respv[2], 0);
        chk("mr_rst_rdata", rdata[2], 0);
        chk("mr_rst_raddr", m_ra[2], 0);
        chk("mr_rst_wout", {m_wa[0], m_wd[0]}, 0);
        rst = 1'b0;
        any_resp = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            any_resp = any_resp | (|respv[2]) | bsy[2];
        end
        chk("mr_no_resp", any_resp, 0);
        rv[2] = 2'b11; ra[2] = {32'd3, 32'd3}; #1;
        chk("mr_ptr_reset", rr[2], 2'b01);
        @(negedge clk); rv[2] = '0;
        repeat (3) @(negedge clk);
        @(negedge clk); #1;
        chk("mr_respv_after", respv[2], 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
